// File: rtl/gauss_feed_pkg.sv
// Shared FSM type and default sizing for the Gaussian sampler random-word feeder.
package gauss_feed_pkg;

  localparam int RND_W          = 64;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_R1 = 3'd1,
    ISSUE_R2 = 3'd2,
    WAIT_VAL = 3'd3,
    DONE     = 3'd4
  } feed_state_e;

endpackage

// File: rtl/gauss_word_fifo.sv
// Small synchronous word FIFO with full/empty flags; depth must be a power of two.
module gauss_word_fifo
  import gauss_feed_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int DATA_W = RND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head word comes straight from the storage flops, so a word written this
  // cycle only becomes visible at the head from the next cycle on.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gauss_rnd_feeder.sv
// Feeds buffered PRNG words to MKGAUSS as r1/r2 pairs, one pair per sample.
// Define GAUSS_FEED_STATS_EN to add the stall_cycles statistics output.
module gauss_rnd_feeder
  import gauss_feed_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             rnd_valid,
  input  logic [RND_W-1:0] rnd,
  output logic             rnd_ready,
  output logic             r1_valid,
  output logic [RND_W-1:0] r1,
  output logic             r2_valid,
  output logic [RND_W-1:0] r2,
  input  logic             val_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             err
`ifdef GAUSS_FEED_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  feed_state_e      state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt_next;
  logic [RND_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issuing;
  logic             pop;

  assign issuing   = (state == ISSUE_R1) || (state == ISSUE_R2);
  assign pop       = issuing && !fifo_empty;
  assign rnd_ready = !fifo_full;
  assign cnt_next  = sample_cnt + 1'b1;

  gauss_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (RND_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rnd_valid),
    .wr_data (rnd),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_lat      <= '0;
      sample_cnt <= '0;
      r1         <= '0;
      r2         <= '0;
      r1_valid   <= 1'b0;
      r2_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      done     <= 1'b0;
      if (val_valid && (state != WAIT_VAL)) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            n_lat      <= n_samples;
            sample_cnt <= '0;
            err        <= val_valid;
            if (n_samples == '0) begin
              state <= DONE;
            end else begin
              state <= ISSUE_R1;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE_R1: begin
          if (!fifo_empty) begin
            r1       <= head;
            r1_valid <= 1'b1;
            state    <= ISSUE_R2;
          end
        end
        ISSUE_R2: begin
          if (!fifo_empty) begin
            r2       <= head;
            r2_valid <= 1'b1;
            state    <= WAIT_VAL;
          end
        end
        WAIT_VAL: begin
          if (val_valid) begin
            sample_cnt <= cnt_next;
            if (cnt_next == n_lat) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ISSUE_R1;
            end
          end
        end
        // A normal run enters with done already high; a zero-length run
        // enters with it low and raises it on the way out.
        DONE: begin
          done  <= !done;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAUSS_FEED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if (issuing && fifo_empty) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_gauss_rnd_feeder.sv
// Self-checking bench for gauss_rnd_feeder: vector table, hand sequences and a
// randomized run checked against a queue-based reference model.
module tb_gauss_rnd_feeder;

  localparam int FD = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] n_samples;
  logic        rnd_valid;
  logic [63:0] rnd;
  logic        rnd_ready;
  logic        r1_valid;
  logic [63:0] r1;
  logic        r2_valid;
  logic [63:0] r2;
  logic        val_valid;
  logic        busy;
  logic        done;
  logic [10:0] sample_cnt;
  logic        err;
`ifdef GAUSS_FEED_STATS_EN
  logic [15:0] stall_cycles;
`endif

  gauss_rnd_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_samples  (n_samples),
    .rnd_valid  (rnd_valid),
    .rnd        (rnd),
    .rnd_ready  (rnd_ready),
    .r1_valid   (r1_valid),
    .r1         (r1),
    .r2_valid   (r2_valid),
    .r2         (r2),
    .val_valid  (val_valid),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err        (err)
`ifdef GAUSS_FEED_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int n;
    int d;
    int exp_done;
    int exp_cnt;
  } vec_t;

  typedef struct {
    logic [63:0] w;
    int          c;
  } word_t;

  // reference model state for the randomized section
  word_t q[$];
  int    mcyc, m_phase, m_cnt, m_n, m_dly, wait_from;
  bit    m_busy, done_next, run_over;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    rnd_valid = 1'b0;
    val_valid = 1'b0;
    rnd = '0;
    n_samples = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic one_sample(input string tag, input logic [63:0] e1, input logic [63:0] e2,
                            input int vcyc);
    start = 1'b1;
    n_samples = 11'd1;
    tick();
    start = 1'b0;
    chk({tag, " busy c1"}, busy, 1);
    chk({tag, " r1_valid c1"}, r1_valid, 0);
    tick();
    chk({tag, " r1_valid c2"}, r1_valid, 1);
    chk({tag, " r1 c2"}, r1, e1);
    chk({tag, " r2_valid c2"}, r2_valid, 0);
    tick();
    chk({tag, " r2_valid c3"}, r2_valid, 1);
    chk({tag, " r2 c3"}, r2, e2);
    chk({tag, " r1_valid c3"}, r1_valid, 0);
    for (int i = 3; i < vcyc; i++) tick();
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " busy at done"}, busy, 0);
    chk({tag, " sample_cnt"}, sample_cnt, 1);
    chk({tag, " r1 held"}, r1, e1);
    tick();
    chk({tag, " done one cycle"}, done, 0);
  endtask

  task automatic run_vec(input int idx, input int n, input int d, input int exp_done,
                         input int exp_cnt);
    logic [63:0] seq, exp_w;
    int  r2c, done_at, done_cnt, busy_bad;
    bit  waiting, acc;
    do_reset();
    seq = 1; exp_w = 1; waiting = 0; r2c = 0;
    done_at = -100; done_cnt = 0; busy_bad = 0;
    for (int r = -4; r <= exp_done + 4; r++) begin
      if (r1_valid) begin
        chk($sformatf("vec%0d r1", idx), r1, exp_w);
        exp_w++;
      end
      if (r2_valid) begin
        chk($sformatf("vec%0d r2", idx), r2, exp_w);
        exp_w++;
        r2c = r;
        waiting = 1;
      end
      if (done) begin
        done_cnt++;
        done_at = r;
      end
      if (r >= 1 && r < exp_done && busy !== (n != 0)) busy_bad++;
      if (r >= exp_done && busy !== 1'b0) busy_bad++;
      start = (r == 0);
      n_samples = n[10:0];
      val_valid = waiting && (r >= r2c + d);
      if (val_valid) waiting = 0;
      rnd_valid = 1'b1;
      rnd = seq;
      acc = rnd_ready;
      tick();
      if (acc) seq++;
    end
    start = 1'b0;
    val_valid = 1'b0;
    rnd_valid = 1'b0;
    chk($sformatf("vec%0d done cycle", idx), done_at, exp_done);
    chk($sformatf("vec%0d done count", idx), done_cnt, 1);
    chk($sformatf("vec%0d sample_cnt", idx), sample_cnt, exp_cnt);
    chk($sformatf("vec%0d words issued", idx), exp_w - 1, 2 * exp_cnt);
    chk($sformatf("vec%0d busy profile", idx), busy_bad, 0);
    chk($sformatf("vec%0d err", idx), err, 0);
  endtask

  task automatic rstep(input bit st, input int n);
    word_t it;
    chk("rand r1/r2 overlap", r1_valid & r2_valid, 0);
    if (r1_valid) begin
      chk("rand r1 order", m_phase, 0);
      chk("rand r1 word available", q.size() > 0, 1);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("rand r1 value", r1, it.w);
        chk("rand r1 word age", it.c <= mcyc - 2, 1);
      end
      m_phase = 1;
    end
    if (r2_valid) begin
      chk("rand r2 order", m_phase, 1);
      chk("rand r2 word available", q.size() > 0, 1);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("rand r2 value", r2, it.w);
        chk("rand r2 word age", it.c <= mcyc - 2, 1);
      end
      m_phase = 2;
      wait_from = mcyc;
      m_dly = $urandom_range(0, 3);
    end
    chk("rand rnd_ready", rnd_ready, q.size() < FD);
    chk("rand done", done, done_next);
    if (done_next) run_over = 1;
    done_next = 0;
    chk("rand busy", busy, m_busy);
    chk("rand sample_cnt", sample_cnt, m_cnt);
    chk("rand err", err, 0);

    start = st;
    n_samples = n[10:0];
    if (st) begin
      m_n = n; m_cnt = 0; m_busy = 1; m_phase = 0; run_over = 0;
    end
    val_valid = (m_phase == 2) && (mcyc >= wait_from + m_dly);
    if (val_valid) begin
      m_cnt++;
      if (m_cnt == m_n) begin
        done_next = 1; m_busy = 0; m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
    rnd_valid = ($urandom_range(0, 9) < 6);
    rnd = {$urandom, $urandom};
    if (rnd_valid && q.size() < FD) begin
      it.w = rnd;
      it.c = mcyc;
      q.push_back(it);
    end
    tick();
    mcyc++;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   early, r2seen, pulses, n;

    vecs[0] = '{n: 1, d: 4, exp_done: 8,  exp_cnt: 1};
    vecs[1] = '{n: 2, d: 0, exp_done: 7,  exp_cnt: 2};
    vecs[2] = '{n: 3, d: 4, exp_done: 22, exp_cnt: 3};
    vecs[3] = '{n: 0, d: 0, exp_done: 2,  exp_cnt: 0};
    vecs[4] = '{n: 4, d: 1, exp_done: 17, exp_cnt: 4};

    // reset state
    rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; val_valid = 1'b0;
    rnd = '0; n_samples = '0;
    #12;
    chk("reset rnd_ready", rnd_ready, 1);
    chk("reset r1", r1, 0);
    chk("reset r2", r2, 0);
    chk("reset r1_valid", r1_valid, 0);
    chk("reset r2_valid", r2_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sample_cnt", sample_cnt, 0);
    chk("reset err", err, 0);
`ifdef GAUSS_FEED_STATS_EN
    chk("reset stall_cycles", stall_cycles, 0);
`endif

    // basic single sample with preloaded words
    do_reset();
    rnd_valid = 1'b1;
    rnd = 64'hA5A5_A5A5_A5A5_A501;
    tick();
    rnd = 64'h2;
    tick();
    rnd_valid = 1'b0;
    one_sample("basic", 64'hA5A5_A5A5_A5A5_A501, 64'h2, 7);
    chk("basic err", err, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i].n, vecs[i].d, vecs[i].exp_done, vecs[i].exp_cnt);

    // empty FIFO at start, first word in cycle 10
    do_reset();
    start = 1'b1;
    n_samples = 11'd1;
    tick();
    start = 1'b0;
    early = 0;
    for (int c = 1; c <= 11; c++) begin
      if (r1_valid) early++;
      if (c == 10) begin
        rnd_valid = 1'b1;
        rnd = 64'h77;
      end
      if (c == 11) rnd = 64'h78;
      tick();
    end
    rnd_valid = 1'b0;
    chk("stall no early r1", early, 0);
    chk("stall r1_valid c12", r1_valid, 1);
    chk("stall r1 c12", r1, 64'h77);
    tick();
    chk("stall r2_valid c13", r2_valid, 1);
    chk("stall r2 c13", r2, 64'h78);
`ifdef GAUSS_FEED_STATS_EN
    chk("stall_cycles >= 9", stall_cycles >= 16'd9, 1);
`endif
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("stall done", done, 1);

    // full FIFO while idle, then release by the first pop
    do_reset();
    rnd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rnd = 64'd100 + 64'(k);
      chk($sformatf("fill ready %0d", k), rnd_ready, 1);
      tick();
    end
    rnd = 64'd104;
    chk("full ready low", rnd_ready, 0);
    tick();
    chk("full 5th not accepted", rnd_ready, 0);
    start = 1'b1;
    n_samples = 11'd1;
    tick();
    start = 1'b0;
    chk("full ready during first pop", rnd_ready, 0);
    tick();
    chk("full ready after pop", rnd_ready, 1);
    chk("full r1", r1, 64'd100);
    tick();
    rnd_valid = 1'b0;
    chk("full r2", r2, 64'd101);
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("full done", done, 1);
    tick();
    one_sample("carry1", 64'd102, 64'd103, 3);
    rnd_valid = 1'b1;
    rnd = 64'd105;
    tick();
    rnd_valid = 1'b0;
    one_sample("carry2", 64'd104, 64'd105, 3);

    // val_valid outside WAIT_VAL
    do_reset();
    rnd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rnd = 64'(k + 1);
      tick();
    end
    rnd_valid = 1'b0;
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("err idle set", err, 1);
    chk("err idle cnt", sample_cnt, 0);
    start = 1'b1;
    n_samples = 11'd1;
    tick();
    start = 1'b0;
    chk("err cleared by start", err, 0);
    tick();
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("err r2 set", err, 1);
    chk("err r2 cnt", sample_cnt, 0);
    chk("err r2_valid", r2_valid, 1);
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("err run done", done, 1);
    chk("err run cnt", sample_cnt, 1);
    chk("err sticky", err, 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err cleared by next start", err, 0);
    tick();
    tick();
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("err second run done", done, 1);

    // async reset during WAIT_VAL of sample 2 of 5
    do_reset();
    n_samples = 11'd5;
    start = 1'b1;
    rnd_valid = 1'b1;
    rnd = {$urandom, $urandom};
    tick();
    start = 1'b0;
    r2seen = 0;
    for (int k = 0; k < 80; k++) begin
      rnd = {$urandom, $urandom};
      val_valid = 1'b0;
      if (r2_valid) begin
        r2seen++;
        if (r2seen == 1) val_valid = 1'b1;
      end
      if (r2seen == 2) break;
      tick();
    end
    chk("rst reached sample 2", r2seen, 2);
    val_valid = 1'b0;
    tick();
    chk("rst pre busy", busy, 1);
    chk("rst pre cnt", sample_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst sample_cnt", sample_cnt, 0);
    chk("rst rnd_ready", rnd_ready, 1);
    chk("rst done", done, 0);
    rnd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (r1_valid || r2_valid || done || busy) pulses++;
    end
    chk("rst no pulses after", pulses, 0);

    // randomized runs against the queue model
    do_reset();
    q.delete();
    mcyc = 0; m_phase = 3; m_cnt = 0; m_n = 0; m_dly = 0; wait_from = 0;
    m_busy = 0; done_next = 0; run_over = 0;
    for (int k = 0; k < 5; k++) rstep(0, 0);
    for (int run = 0; run < 8; run++) begin
      n = $urandom_range(1, 6);
      rstep(1, n);
      for (int k = 0; k < 300 && !run_over; k++) rstep(0, 0);
      chk($sformatf("rand run %0d completes", run), run_over, 1);
      rstep(0, 0);
    end
    start = 1'b0;
    rnd_valid = 1'b0;
    val_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
